// File: rtl/flex_pkg.sv
// ============================================================================
// Module  : flex_pkg
// Brief   : Shared types and constants for the flex word packer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package flex_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } packer_state_t;
endpackage

`default_nettype wire

// File: rtl/flex_byte_slot_sel.sv
// ============================================================================
// Module  : flex_byte_slot_sel
// Brief   : Maps the byte counter to a one-hot byte-lane enable, honouring
//           the configured byte order.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flex_byte_slot_sel #(
    parameter int NUM_BYTES  = 4,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int CNT_W      = 3
) (
    input  logic [CNT_W-1:0]     cnt,
    output logic [NUM_BYTES-1:0] slot_en
);

    // Lane index 0 is out_data[7:0]; big-endian puts slot 0 in the top lane.
    for (genvar i = 0; i < NUM_BYTES; i++) begin : g_slot
        localparam int POS = BIG_ENDIAN ? (NUM_BYTES - 1 - i) : i;
        assign slot_en[POS] = (cnt == CNT_W'(i));
    end

endmodule

`default_nettype wire

// File: rtl/flex_word_packer.sv
// ============================================================================
// Module  : flex_word_packer
// Brief   : Byte-serial to NUM_BITS word packer with zero-bubble handoff.
//           Optional flush port enabled by FLEX_PACKER_FLUSH_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module flex_word_packer
    import flex_pkg::*;
#(
    parameter int NUM_BITS   = 32,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    input  logic [7:0]                        in_data,
    output logic                              in_ready,
    output logic                              out_valid,
    output logic [NUM_BITS-1:0]               out_data,
    input  logic                              out_ready,
`ifdef FLEX_PACKER_FLUSH_EN
    input  logic                              flush,
`endif
    output logic [$clog2(NUM_BITS/8+1)-1:0]   out_bytes
);

    localparam int NB    = NUM_BITS / BYTE_W;
    localparam int CNT_W = $clog2(NB + 1);

    packer_state_t         state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [CNT_W-1:0]      bytes_q, bytes_next;
    logic [NUM_BITS-1:0]   word, word_next;
    logic [NUM_BITS-1:0]   lane_mask, placed;
    logic [NB-1:0]         slot_en;
    logic                  accept, last_byte, flush_req;

`ifdef FLEX_PACKER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    flex_byte_slot_sel #(
        .NUM_BYTES  (NB),
        .BIG_ENDIAN (BIG_ENDIAN),
        .CNT_W      (CNT_W)
    ) u_slot_sel (
        .cnt     (cnt),
        .slot_en (slot_en)
    );

    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{slot_en[i]}};
    end

    assign placed    = lane_mask & {NB{in_data}};
    assign accept    = in_valid & in_ready;
    assign last_byte = (cnt == CNT_W'(NB - 1));
    assign out_data  = word;
    assign out_bytes = bytes_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= FILL;
            cnt     <= '0;
            bytes_q <= '0;
            word    <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            bytes_q <= bytes_next;
            word    <= word_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bytes_next = bytes_q;
        word_next  = word;
        case (state)
            FILL: begin
                if (accept) begin
                    word_next = (word & ~lane_mask) | placed;
                    if (last_byte) begin
                        state_next = FULL;
                        cnt_next   = '0;
                        bytes_next = CNT_W'(NB);
                    end else if (flush_req) begin
                        state_next = FULL;
                        cnt_next   = '0;
                        bytes_next = cnt + 1'b1;
                    end else begin
                        cnt_next   = cnt + 1'b1;
                    end
                end else if (flush_req && (cnt != '0)) begin
                    state_next = FULL;
                    cnt_next   = '0;
                    bytes_next = cnt;
                end
            end
            FULL: begin
                // cnt is 0 here, so slot_en already targets slot 0 of the next word.
                if (out_ready) begin
                    state_next = FILL;
                    bytes_next = '0;
                    word_next  = accept ? placed : '0;
                    cnt_next   = accept ? CNT_W'(1) : '0;
                end
            end
            default: state_next = FILL;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        if (!rst) begin
            case (state)
                FILL: in_ready = 1'b1;
                FULL: begin
                    in_ready  = out_ready;
                    out_valid = 1'b1;
                end
                default: in_ready = 1'b0;
            endcase
        end
    end

endmodule

`default_nettype wire
